// File: rtl/interp_and_fir.sv
// Interpolate-by-2 half-band filter: two 8-tap polyphase branches sharing one serial MAC.
// Optional output saturation is enabled by defining INTERP_SAT_EN; otherwise the output wraps.
module interp_and_fir #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         single_valid_in,
  input  logic [4:0]                   right_shift,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         ifir_valid_out,
  output logic signed [DATA_WIDTH-1:0] ifir_data_out,
  output logic                         overrun
);

  localparam int unsigned COEF_W = 16;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned TAP_W  = 3;
  localparam int unsigned PROD_W = COEF_W + DATA_WIDTH;
  localparam int unsigned ACC_W  = DATA_WIDTH + COEF_W + 3;

  // Polyphase split of h = -1,0,3,0,-9,0,23,32,23,0,-9,0,3,0,-1,0
  localparam logic signed [COEF_W-1:0] HE [TAPS] = '{
    -16'sd1, 16'sd3, -16'sd9, 16'sd23, 16'sd23, -16'sd9, 16'sd3, -16'sd1
  };
  localparam logic signed [COEF_W-1:0] HO [TAPS] = '{
    16'sd0, 16'sd0, 16'sd0, 16'sd32, 16'sd0, 16'sd0, 16'sd0, 16'sd0
  };

`ifdef INTERP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_E = 3'd1,
    OUT_E = 3'd2,
    MAC_O = 3'd3,
    OUT_O = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [DATA_WIDTH-1:0] x [TAPS];
  logic signed [ACC_W-1:0]      acc;
  logic [TAP_W-1:0]             tap;

  logic                         accept_c;
  logic                         drop_c;
  logic                         mac_c;
  logic                         out_c;
  logic signed [COEF_W-1:0]     coef_c;
  logic signed [DATA_WIDTH-1:0] sample_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      shifted_c;
  logic signed [DATA_WIDTH-1:0] result_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (single_valid_in) next_state = MAC_E;
      MAC_E:   if (tap == TAP_W'(TAPS - 1)) next_state = OUT_E;
      OUT_E:   next_state = MAC_O;
      MAC_O:   if (tap == TAP_W'(TAPS - 1)) next_state = OUT_O;
      OUT_O:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    accept_c = 1'b0;
    drop_c   = 1'b0;
    mac_c    = 1'b0;
    out_c    = 1'b0;
    case (state)
      IDLE:         accept_c = single_valid_in;
      MAC_E, MAC_O: mac_c    = 1'b1;
      OUT_E, OUT_O: out_c    = 1'b1;
      default:      ;
    endcase
    if (state != IDLE) drop_c = single_valid_in;
  end

  // One product per MAC cycle; phase chosen by the state
  always_comb begin
    coef_c   = (state == MAC_O) ? HO[tap] : HE[tap];
    sample_c = x[tap];
    prod_c   = coef_c * sample_c;
  end

  // Floor shift then wrap or clamp to the output width
  always_comb begin
    shifted_c = acc >>> right_shift;
`ifdef INTERP_SAT_EN
    if (shifted_c > SAT_MAX) begin
      result_c = DATA_WIDTH'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      result_c = DATA_WIDTH'(SAT_MIN);
    end else begin
      result_c = DATA_WIDTH'(shifted_c);
    end
`else
    result_c = DATA_WIDTH'(shifted_c);
`endif
  end

  // Delay line, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS); k++) x[k] <= '0;
      acc            <= '0;
      tap            <= '0;
      ifir_valid_out <= 1'b0;
      ifir_data_out  <= '0;
      overrun        <= 1'b0;
    end else begin
      ifir_valid_out <= out_c;
      overrun        <= overrun | drop_c;
      if (accept_c) begin
        for (int k = int'(TAPS) - 1; k > 0; k--) x[k] <= x[k-1];
        x[0] <= data_in;
        acc  <= '0;
        tap  <= '0;
      end
      // tap wraps 7 -> 0, so the odd phase starts from tap 0 as well
      if (mac_c) begin
        acc <= acc + ACC_W'(prod_c);
        tap <= tap + TAP_W'(1);
      end
      if (out_c) begin
        ifir_data_out <= result_c;
        acc           <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interp_and_fir.sv
// Scoreboard bench for interp_and_fir: expected samples are queued when inputs are
// driven and compared in order as output pulses appear.
module tb_interp_and_fir;

  localparam int unsigned DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 single_valid_in = 1'b0;
  logic [4:0]           right_shift = 5'd0;
  logic signed [DW-1:0] data_in = '0;
  logic                 ifir_valid_out;
  logic signed [DW-1:0] ifir_data_out;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] mx [8];
  logic signed [DW-1:0] exp_v;
  logic                 rst_q;
  logic                 prev_valid = 1'b0;
  logic signed [DW-1:0] prev_data = '0;

  int he [8] = '{-1, 3, -9, 23, 23, -9, 3, -1};
  int ho [8] = '{0, 0, 0, 32, 0, 0, 0, 0};

  interp_and_fir #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .single_valid_in (single_valid_in),
    .right_shift     (right_shift),
    .data_in         (data_in),
    .ifir_valid_out  (ifir_valid_out),
    .ifir_data_out   (ifir_data_out),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic signed [DW-1:0] model_out(input int phase, input int sh);
    longint acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc += longint'((phase == 0) ? he[k] : ho[k]) * longint'(mx[k]);
    end
    acc = acc >>> sh;
`ifdef INTERP_SAT_EN
    if (acc > longint'(2 ** (DW - 1) - 1)) acc = longint'(2 ** (DW - 1) - 1);
    if (acc < -longint'(2 ** (DW - 1)))    acc = -longint'(2 ** (DW - 1));
`endif
    return DW'(acc);
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Output monitor: pulses pop the scoreboard, idle cycles must hold the data
  always @(negedge clk) begin
    if (!rst && rst_q === 1'b0) begin
      if (ifir_valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: data=%0d with no expected sample queued", ifir_data_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (ifir_data_out !== exp_v) begin
            errors++;
            $display("FAIL output_sample: got %0d expected %0d at %0t", ifir_data_out, exp_v, $time);
          end
        end
        checks++;
        if (prev_valid !== 1'b0) begin
          errors++;
          $display("FAIL pulse_width: ifir_valid_out high two cycles in a row at %0t", $time);
        end
      end else begin
        checks++;
        if (ifir_data_out !== prev_data) begin
          errors++;
          $display("FAIL data_hold: got %0d expected held %0d at %0t", ifir_data_out, prev_data, $time);
        end
      end
    end
    prev_valid = ifir_valid_out;
    prev_data  = ifir_data_out;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic signed [DW-1:0] d, input logic [4:0] sh);
    data_in         = d;
    right_shift     = sh;
    single_valid_in = 1'b1;
    @(posedge clk);
    #1;
    single_valid_in = 1'b0;
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
  endtask

  task automatic send(input logic signed [DW-1:0] d, input logic [4:0] sh);
    drive_in(d, sh);
    exp_q.push_back(model_out(0, int'(sh)));
    exp_q.push_back(model_out(1, int'(sh)));
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    single_valid_in = 1'b1;
    data_in         = 16'sd12345;
    wait_cyc(2);
    rst             = 1'b0;
    single_valid_in = 1'b0;
    for (int k = 0; k < 8; k++) mx[k] = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if (ifir_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", ifir_valid_out);
    end
    checks++;
    if (ifir_data_out !== 16'sd0) begin
      errors++; $display("FAIL reset_data: got %0d expected 0", ifir_data_out);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
    do_reset();
  endtask

  task automatic test_impulse();
    logic signed [DW-1:0] tbl [20];
    tbl = '{-16'sd32, 16'sd0, 16'sd93, 16'sd0, -16'sd282, 16'sd0, 16'sd718, 16'sd1000,
            16'sd718, 16'sd0, -16'sd282, 16'sd0, 16'sd93, 16'sd0, -16'sd32, 16'sd0,
            16'sd0, 16'sd0, 16'sd0, 16'sd0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_in((i == 0) ? 16'sd1000 : 16'sd0, 5'd5);
      exp_q.push_back(tbl[2*i]);
      exp_q.push_back(tbl[2*i+1]);
      wait_cyc(19);
    end
    wait_cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL impulse_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin
        send(16'sd1000, 5'd5);
      end else begin
        drive_in(16'sd1000, 5'd5);
        exp_q.push_back(16'sd1000);
        exp_q.push_back(16'sd1000);
      end
      wait_cyc(19);
    end
    wait_cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL dc_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] sat_exp;
`ifdef INTERP_SAT_EN
    sat_exp = 16'sd32767;
`else
    sat_exp = -16'sd32;
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        send(16'sd32767, 5'd0);
      end else begin
        drive_in(16'sd32767, 5'd0);
        exp_q.push_back(sat_exp);
        exp_q.push_back(sat_exp);
      end
      wait_cyc(19);
    end
    wait_cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sat_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_latency();
    logic want;
    do_reset();
    send(-16'sd200, 5'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      want = (k == 10) || (k == 19);
      checks++;
      if (ifir_valid_out !== want) begin
        errors++; $display("FAIL latency_t+%0d: valid got %b expected %b", k, ifir_valid_out, want);
      end
    end
    wait_cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL latency_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send(16'sd5, 5'd2);
    wait_cyc(4);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_early: got %b expected 0", overrun);
    end
    data_in         = 16'sd7;
    single_valid_in = 1'b1;
    @(posedge clk);
    #1;
    single_valid_in = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    wait_cyc(14);
    send(16'sd0, 5'd2);
    wait_cyc(24);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL overrun_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    drive_in(16'sd1000, 5'd5);
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) mx[k] = '0;
    exp_q.delete();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (ifir_valid_out !== 1'b0 || ifir_data_out !== 16'sd0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_mac: valid=%b data=%0d overrun=%b expected 0/0/0",
                 ifir_valid_out, ifir_data_out, overrun);
      end
    end
    wait_cyc(1);
    drive_in(16'sd1000, 5'd5);
    exp_q.push_back(-16'sd32);
    exp_q.push_back(16'sd0);
    wait_cyc(24);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_mac_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(DW'($urandom), 5'd4);
      wait_cyc(18);
    end
    wait_cyc(6);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: %0d samples never arrived, expected 0", exp_q.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mx[k] = '0;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_latency();
    test_overrun();
    test_reset_mid_mac();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
